// File: rtl/uart_wb_master.sv
// UART-to-Wishbone debug master: 8N1 host frames become single 32-bit bus cycles.
// Define UART_WB_TIMEOUT_EN to build the bus watchdog (status 0x02 on expiry).
module uart_wb_master #(
   parameter int CLKS_PER_BIT   = 104,
   parameter int ADDR_WIDTH     = 32,
   parameter int TAG_WIDTH      = 1,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  uart_rx,
   output logic                  uart_tx,
   output logic                  wb_cyc,
   output logic                  wb_stb,
   output logic                  wb_we,
   output logic [TAG_WIDTH-1:0]  wb_tag,
   output logic [3:0]            wb_sel,
   output logic [ADDR_WIDTH-1:0] wb_adr,
   output logic [31:0]           wb_mosi,
   input  logic [31:0]           wb_miso,
   input  logic                  wb_ack,
   input  logic                  wb_err,
   output logic                  busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF    = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_st_t;
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_STAT, S_SEND} st_t;

   // ---------------- RX ----------------
   logic          rx_s1_q, rx_s2_q, rx_s3_q;
   rx_st_t        rx_st_q, rx_st_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_sh_q, rx_sh_d;
   logic          rx_vld_q, rx_vld_d;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rx_s1_q  <= 1'b1;
         rx_s2_q  <= 1'b1;
         rx_s3_q  <= 1'b1;
         rx_st_q  <= RX_IDLE;
         rx_cnt_q <= '0;
         rx_bit_q <= '0;
         rx_sh_q  <= '0;
         rx_vld_q <= 1'b0;
      end else begin
         rx_s1_q  <= uart_rx;
         rx_s2_q  <= rx_s1_q;
         rx_s3_q  <= rx_s2_q;
         rx_st_q  <= rx_st_d;
         rx_cnt_q <= rx_cnt_d;
         rx_bit_q <= rx_bit_d;
         rx_sh_q  <= rx_sh_d;
         rx_vld_q <= rx_vld_d;
      end
   end

   always_comb begin
      rx_st_d  = rx_st_q;
      rx_cnt_d = rx_cnt_q + 1'b1;
      rx_bit_d = rx_bit_q;
      rx_sh_d  = rx_sh_q;
      rx_vld_d = 1'b0;
      case (rx_st_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rx_s3_q && !rx_s2_q) rx_st_d = RX_START;
         end
         RX_START: if (rx_cnt_q == HALF) begin
            rx_cnt_d = '0;
            rx_bit_d = '0;
            rx_st_d  = rx_s2_q ? RX_IDLE : RX_BITS;
         end
         RX_BITS: if (rx_cnt_q == BIT_END) begin
            rx_cnt_d = '0;
            rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
         end
         RX_STOP: if (rx_cnt_q == BIT_END) begin
            rx_st_d  = RX_IDLE;
            rx_vld_d = rx_s2_q;  // low stop bit: framing error, byte dropped
         end
         default: rx_st_d = RX_IDLE;
      endcase
   end

   // ---------------- TX ----------------
   logic [9:0]    tx_sh_q;
   logic [CW-1:0] tx_cnt_q;
   logic [3:0]    tx_bit_q;
   logic          tx_busy_q, tx_end, tx_ld, tx_acc;
   logic [7:0]    tx_byte;

   // A new byte may load on the last stop-bit cycle so bytes run back-to-back.
   assign tx_end  = tx_busy_q && (tx_bit_q == 4'd9) && (tx_cnt_q == BIT_END);
   assign tx_acc  = tx_ld && (!tx_busy_q || tx_end);
   assign uart_tx = tx_sh_q[0];

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         tx_sh_q   <= '1;
         tx_cnt_q  <= '0;
         tx_bit_q  <= '0;
         tx_busy_q <= 1'b0;
      end else if (tx_acc) begin
         tx_sh_q   <= {1'b1, tx_byte, 1'b0};
         tx_cnt_q  <= '0;
         tx_bit_q  <= '0;
         tx_busy_q <= 1'b1;
      end else if (tx_busy_q) begin
         if (tx_cnt_q == BIT_END) begin
            tx_cnt_q <= '0;
            tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
            tx_bit_q <= tx_bit_q + 1'b1;
            if (tx_bit_q == 4'd9) tx_busy_q <= 1'b0;
         end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
         end
      end
   end

   // ---------------- frame / bus FSM ----------------
   st_t         st_q, st_d;
   logic        we_q, we_d;
   logic [2:0]  bcnt_q, bcnt_d;
   logic [31:0] adr_q, adr_d, dat_q, dat_d;
   logic [1:0]  stat_q, stat_d;
   logic        tmo_hit;

`ifdef UART_WB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tmo_q;
   always_ff @(posedge sys_clk) begin
      if (sys_rst || st_q != S_BUS) tmo_q <= '0;
      else                          tmo_q <= tmo_q + 1'b1;
   end
   assign tmo_hit = (tmo_q == TMO_END);
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         st_q   <= S_IDLE;
         we_q   <= 1'b0;
         bcnt_q <= '0;
         adr_q  <= '0;
         dat_q  <= '0;
         stat_q <= '0;
      end else begin
         st_q   <= st_d;
         we_q   <= we_d;
         bcnt_q <= bcnt_d;
         adr_q  <= adr_d;
         dat_q  <= dat_d;
         stat_q <= stat_d;
      end
   end

   always_comb begin
      st_d    = st_q;
      we_d    = we_q;
      bcnt_d  = bcnt_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      stat_d  = stat_q;
      tx_ld   = 1'b0;
      tx_byte = 8'h00;
      case (st_q)
         S_IDLE: if (rx_vld_q && (rx_sh_q == 8'h01 || rx_sh_q == 8'h02)) begin
            we_d   = (rx_sh_q == 8'h01);
            bcnt_d = '0;
            st_d   = S_ADDR;
         end
         S_ADDR: if (rx_vld_q) begin
            adr_d  = {adr_q[23:0], rx_sh_q};
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd3) begin
               bcnt_d = '0;
               st_d   = we_q ? S_DATA : S_BUS;
            end
         end
         S_DATA: if (rx_vld_q) begin
            dat_d  = {dat_q[23:0], rx_sh_q};
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd3) st_d = S_BUS;
         end
         S_BUS: begin
            if (wb_err) begin
               stat_d = 2'd1;
               st_d   = S_STAT;
            end else if (wb_ack) begin
               stat_d = 2'd0;
               if (!we_q) dat_d = wb_miso;
               st_d   = S_STAT;
            end else if (tmo_hit) begin
               stat_d = 2'd2;
               st_d   = S_STAT;
            end
         end
         S_STAT: begin
            tx_ld   = 1'b1;
            tx_byte = {6'd0, stat_q};
            if (tx_acc) begin
               st_d   = S_SEND;
               bcnt_d = (stat_q == 2'd0 && !we_q) ? 3'd0 : 3'd4;
            end
         end
         S_SEND: begin
            // bcnt==4: everything queued, wait for the last stop bit to finish
            if (bcnt_q != 3'd4) begin
               tx_ld   = 1'b1;
               tx_byte = dat_q[31:24];
               if (tx_acc) begin
                  dat_d  = {dat_q[23:0], 8'h00};
                  bcnt_d = bcnt_q + 3'd1;
               end
            end else if (!tx_busy_q) begin
               st_d = S_IDLE;
            end
         end
         default: st_d = S_IDLE;
      endcase
   end

   assign wb_cyc  = (st_q == S_BUS);
   assign wb_stb  = wb_cyc;
   assign wb_we   = wb_cyc && we_q;
   assign wb_sel  = {4{wb_cyc}};
   assign wb_tag  = '0;
   assign wb_adr  = adr_q[ADDR_WIDTH-1:0];
   assign wb_mosi = dat_q;
   assign busy    = (st_q != S_IDLE);
endmodule

// File: tb/tb_uart_wb_master.sv
// Directed bench for uart_wb_master: frame-level model, bus slave, serial TX monitor.
module tb_uart_wb_master;
   localparam int CPB = 4;
   localparam int TMO = 16;

   logic        sys_clk = 1'b0, sys_rst = 1'b1, uart_rx = 1'b1;
   logic        uart_tx, wb_cyc, wb_stb, wb_we, busy;
   logic [0:0]  wb_tag;
   logic [3:0]  wb_sel;
   logic [31:0] wb_adr, wb_mosi;
   logic [31:0] wb_miso = 32'h0;
   logic        wb_ack = 1'b0, wb_err = 1'b0;

   uart_wb_master #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(32), .TAG_WIDTH(1), .TIMEOUT_CYCLES(TMO)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_tag(wb_tag), .wb_sel(wb_sel),
      .wb_adr(wb_adr), .wb_mosi(wb_mosi), .wb_miso(wb_miso), .wb_ack(wb_ack),
      .wb_err(wb_err), .busy(busy));

   always #5 sys_clk = ~sys_clk;

   int n_chk = 0, n_pass = 0;
   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   longint cyc_n = 0;
   always @(posedge sys_clk) cyc_n++;

   // Slave: mode 0 silent, 1 ack, 2 err, 3 ack+err; responds after slv_dly cycles of cyc.
   int slv_mode = 1, slv_dly = 0, cyc_len = 0, last_len = 0, n_bus = 0;
   always @(negedge sys_clk) begin
      if (wb_cyc) begin
         cyc_len++;
         wb_ack = (slv_mode == 1 || slv_mode == 3) && cyc_len > slv_dly;
         wb_err = (slv_mode == 2 || slv_mode == 3) && cyc_len > slv_dly;
      end else begin
         if (cyc_len != 0) begin last_len = cyc_len; n_bus++; end
         cyc_len = 0; wb_ack = 1'b0; wb_err = 1'b0;
      end
   end

   // Per-cycle bus check against the frame model.
   logic [31:0] exp_adr = 0, exp_dat = 0, cap_adr = 0, cap_mosi = 0;
   logic        exp_we = 1'b0;
   always @(negedge sys_clk) begin
      if (!sys_rst && wb_cyc) begin
         cap_adr = wb_adr; cap_mosi = wb_mosi;
         chk({busy, wb_stb, wb_we, wb_sel, wb_tag} == {1'b1, 1'b1, exp_we, 4'hF, 1'b0}, "bus_ctl",
             {busy, wb_stb, wb_we, wb_sel, wb_tag}, {1'b1, 1'b1, exp_we, 4'hF, 1'b0});
         chk({exp_we ? wb_mosi : 32'h0, wb_adr} == {exp_we ? exp_dat : 32'h0, exp_adr}, "bus_adr_data",
             {wb_mosi, wb_adr}, {exp_dat, exp_adr});
      end
   end

   // Serial monitor: every cycle of a TX byte must match the expected 8N1 waveform.
   logic [7:0] exp_tx[$];
   logic [7:0] rx_log[$];
   longint     st_log[$];
   bit         mon_active = 0;
   initial begin : mon
      logic prev; logic [9:0] pat; logic [7:0] got, e; bit ok, unexp;
      prev = 1'b1;
      forever begin
         @(negedge sys_clk);
         if (!sys_rst && prev && !uart_tx) begin
            mon_active = 1; st_log.push_back(cyc_n);
            unexp = (exp_tx.size() == 0);
            e = unexp ? 8'h00 : exp_tx.pop_front();
            pat = {1'b1, e, 1'b0}; ok = 1; got = 8'h00;
            for (int i = 0; i < 10*CPB; i++) begin
               if (i > 0) @(negedge sys_clk);
               if (uart_tx !== pat[i/CPB]) ok = 0;
               if (i % CPB == CPB/2 && i/CPB >= 1 && i/CPB <= 8) got[i/CPB-1] = uart_tx;
            end
            rx_log.push_back(got);
            if (unexp) chk(1'b0, "tx_unexpected_byte", got, 0);
            else       chk(ok, "tx_byte", got, e);
            mon_active = 0;
         end
         prev = uart_tx;
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stp);
      uart_rx = 1'b0; repeat (CPB) @(negedge sys_clk);
      for (int i = 0; i < 8; i++) begin uart_rx = b[i]; repeat (CPB) @(negedge sys_clk); end
      uart_rx = stp; repeat (CPB) @(negedge sys_clk);
      uart_rx = 1'b1; repeat (2*CPB) @(negedge sys_clk);
   endtask

   task automatic run_frame(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat,
                            input int mode, input int dly, input logic [31:0] miso, input string name);
      int n0, exp_len, t; logic [7:0] st; bit gap_ok;
      exp_adr = adr; exp_dat = dat; exp_we = (cmd == 8'h01);
      slv_mode = mode; slv_dly = dly; wb_miso = miso;
      rx_log.delete(); st_log.delete(); n0 = n_bus;
      st = (mode == 1) ? 8'h00 : (mode == 0) ? 8'h02 : 8'h01;
      exp_tx.push_back(st);
      if (cmd == 8'h02 && mode == 1) for (int i = 3; i >= 0; i--) exp_tx.push_back(miso[8*i +: 8]);
      exp_len = (mode == 0) ? TMO : dly + 1;
      send_byte(cmd, 1'b1);
      for (int i = 3; i >= 0; i--) send_byte(adr[8*i +: 8], 1'b1);
      if (cmd == 8'h01) for (int i = 3; i >= 0; i--) send_byte(dat[8*i +: 8], 1'b1);
      t = 0;
      while ((exp_tx.size() != 0 || mon_active) && t < 3000) begin @(negedge sys_clk); t++; end
      chk(t < 3000, {name, " tx_drain"}, t, 3000);
      repeat (4) @(negedge sys_clk);
      chk(n_bus == n0 + 1, {name, " bus_count"}, n_bus - n0, 1);
      chk(last_len == exp_len, {name, " cyc_len"}, last_len, exp_len);
      chk(busy == 1'b0 && uart_tx == 1'b1, {name, " idle_after"}, {busy, uart_tx}, 2'b01);
      if (st_log.size() > 1) begin
         gap_ok = 1;
         for (int i = 1; i < st_log.size(); i++) if (st_log[i] - st_log[i-1] != 10*CPB) gap_ok = 0;
         chk(gap_ok, {name, " tx_back_to_back"}, st_log[st_log.size()-1] - st_log[0],
             10*CPB*(st_log.size()-1));
      end
   endtask

   initial begin : wdog
      repeat (60000) @(posedge sys_clk);
      $display("FAIL watchdog: simulation exceeded 60000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int t, n0;
      repeat (3) @(negedge sys_clk);
      chk({uart_tx, wb_cyc, wb_stb, wb_we, wb_sel, wb_tag, busy} == 10'b1_0_0_0_0000_0_0, "reset_ctl",
          {uart_tx, wb_cyc, wb_stb, wb_we, wb_sel, wb_tag, busy}, 10'b1000000000);
      chk({wb_adr, wb_mosi} == 64'h0, "reset_adr_data", {wb_adr, wb_mosi}, 64'h0);
      sys_rst = 1'b0;
      repeat (5) @(negedge sys_clk);

      // write with 2-cycle slave latency
      run_frame(8'h01, 32'h0000_4000, 32'hDEAD_BEEF, 1, 2, 32'h0, "write");
      chk(cap_adr == 32'h0000_4000, "write lit_adr", cap_adr, 32'h0000_4000);
      chk(cap_mosi == 32'hDEAD_BEEF, "write lit_mosi", cap_mosi, 32'hDEAD_BEEF);
      chk(rx_log.size() == 1 && rx_log[0] == 8'h00, "write lit_resp", rx_log.size(), 1);

      // read, ack on the first strobe cycle
      run_frame(8'h02, 32'h0000_4000, 32'h0, 1, 0, 32'h1234_5678, "read");
      if (rx_log.size() == 5)
         chk({rx_log[0], rx_log[1], rx_log[2], rx_log[3], rx_log[4]} == 40'h00_1234_5678, "read lit_resp",
             {rx_log[0], rx_log[1], rx_log[2], rx_log[3], rx_log[4]}, 40'h00_1234_5678);
      else chk(1'b0, "read lit_resp_len", rx_log.size(), 5);

      // bus error: status only
      run_frame(8'h02, 32'h0001_0000, 32'h0, 2, 1, 32'hFFFF_FFFF, "bus_err");
      chk(rx_log.size() == 1 && rx_log[0] == 8'h01, "bus_err lit_resp", rx_log.size(), 1);

      // ack and err together count as err
      run_frame(8'h02, 32'h0000_0100, 32'h0, 3, 0, 32'hCAFE_F00D, "ack_err");

      // unknown command and framing error are dropped
      n0 = n_bus; rx_log.delete();
      send_byte(8'h7F, 1'b1);
      send_byte(8'h02, 1'b0);
      repeat (40) @(negedge sys_clk);
      chk(n_bus == n0 && busy == 1'b0, "bad_frames_ignored", {n_bus - n0, busy}, 0);
      chk(rx_log.size() == 0, "bad_frames_no_tx", rx_log.size(), 0);
      run_frame(8'h02, 32'h0000_0010, 32'h0, 1, 1, 32'hA5A5_0F0F, "read_after_bad");

`ifdef UART_WB_TIMEOUT_EN
      run_frame(8'h02, 32'h0000_0030, 32'h0, 0, 0, 32'h0, "timeout");
`endif

      // reset during BUS aborts the cycle with no response
      exp_adr = 32'h0000_0020; exp_we = 1'b0; slv_mode = 0; rx_log.delete();
      send_byte(8'h02, 1'b1);
      for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
      send_byte(8'h20, 1'b1);
      t = 0;
      while (!wb_cyc && t < 500) begin @(negedge sys_clk); t++; end
      chk(wb_cyc, "rst_cyc_started", wb_cyc, 1);
`ifdef UART_WB_TIMEOUT_EN
      repeat (5) @(negedge sys_clk);
`else
      repeat (200) @(negedge sys_clk);
      chk(wb_cyc && busy, "no_timeout_hold", {wb_cyc, busy}, 2'b11);
`endif
      sys_rst = 1'b1;
      @(negedge sys_clk);
      chk({wb_cyc, wb_stb, uart_tx, busy} == 4'b0010, "rst_abort", {wb_cyc, wb_stb, uart_tx, busy}, 4'b0010);
      sys_rst = 1'b0;
      repeat (100) @(negedge sys_clk);
      chk(rx_log.size() == 0, "rst_no_response", rx_log.size(), 0);
      run_frame(8'h01, 32'h0000_0008, 32'h0102_0304, 1, 3, 32'h0, "write_after_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
